eth_tx_frame_sequencer: RTL and testbench

Frame-level controller that sits upstream of the nibble transmitter and sequences each Ethernet frame onto its byte-wide valid/ready input. It emits preamble and SFD, forwards payload bytes from a packet source, pads short frames, appends FCS, and enforces the inter-frame gap. It also detects source underrun mid-frame and aborts the frame cleanly.

---
 rtl/eth_tx_frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_eth_tx_frame_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_sequencer.sv
// Ethernet TX frame sequencer: preamble/SFD, payload forwarding, padding, FCS and IFG
// onto a byte-wide valid/ready link, with clean abort on source underrun.
module eth_tx_frame_sequencer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG, S_DRAIN
  } state_t;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
      else      c = c >> 1;
    end
    return c;
  endfunction

  state_t      r_state;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic [31:0] r_crc;
  logic [10:0] r_byte_cnt;
  logic [3:0]  r_pre_cnt;
  logic [1:0]  r_fcs_idx;
  logic [7:0]  r_ifg_cnt;
  logic        r_underrun;
  logic [15:0] r_frame_count;

  logic        w_adv;
  logic [10:0] w_byte_cnt_inc;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_byte;

  assign w_adv          = !r_out_valid || out_ready;
  assign w_byte_cnt_inc = (r_byte_cnt == 11'd2047) ? r_byte_cnt : r_byte_cnt + 11'd1;
  assign w_fcs          = ~r_crc;

  always_comb begin
    case (r_fcs_idx)
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      default: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  assign in_ready    = (r_state == S_DRAIN) || ((r_state == S_PAYLOAD) && w_adv);
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state != S_IDLE);
  assign underrun    = r_underrun;
  assign frame_count = r_frame_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_out_data    <= 8'h00;
      r_out_valid   <= 1'b0;
      r_crc         <= 32'hFFFFFFFF;
      r_byte_cnt    <= 11'd0;
      r_pre_cnt     <= 4'd0;
      r_fcs_idx     <= 2'd0;
      r_ifg_cnt     <= 8'd0;
      r_underrun    <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_underrun <= 1'b0;
      // A consumed output byte empties the register unless a state below reloads it.
      if (w_adv) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_byte_cnt <= 11'd0;
          r_crc      <= 32'hFFFFFFFF;
          r_pre_cnt  <= 4'd0;
          r_fcs_idx  <= 2'd0;
          r_ifg_cnt  <= 8'd0;
          if (in_valid) r_state <= S_PREAMBLE;
        end
        S_PREAMBLE: if (w_adv) begin
          r_out_data  <= 8'h55;
          r_out_valid <= 1'b1;
          if (r_pre_cnt == 4'(PREAMBLE_LEN - 1)) r_state <= S_SFD;
          else r_pre_cnt <= r_pre_cnt + 4'd1;
        end
        S_SFD: if (w_adv) begin
          r_out_data  <= 8'hD5;
          r_out_valid <= 1'b1;
          r_state     <= S_PAYLOAD;
        end
        S_PAYLOAD: if (w_adv) begin
          if (in_valid) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
            r_crc       <= crc32_byte(r_crc, in_data);
            r_byte_cnt  <= w_byte_cnt_inc;
            if (in_last) r_state <= (w_byte_cnt_inc < 11'(MIN_FRAME)) ? S_PAD : S_FCS;
          end else begin
            // Source starved mid-frame: abort and swallow the rest of the frame.
            r_underrun <= 1'b1;
            r_state    <= S_DRAIN;
          end
        end
        S_PAD: if (w_adv) begin
          r_out_data  <= 8'h00;
          r_out_valid <= 1'b1;
          r_crc       <= crc32_byte(r_crc, 8'h00);
          r_byte_cnt  <= w_byte_cnt_inc;
          if (w_byte_cnt_inc >= 11'(MIN_FRAME)) r_state <= S_FCS;
        end
        S_FCS: if (w_adv) begin
          r_out_data  <= w_fcs_byte;
          r_out_valid <= 1'b1;
          r_fcs_idx   <= r_fcs_idx + 2'd1;
          if (r_fcs_idx == 2'd3) begin
            r_state       <= S_IFG;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        // The gap counts from the edge that accepts the final FCS byte.
        S_IFG: if (w_adv) begin
          r_ifg_cnt <= r_ifg_cnt + 8'd1;
          if (r_ifg_cnt == 8'(IFG_CYCLES - 1)) r_state <= S_IDLE;
        end
        S_DRAIN: if (in_valid && in_last) r_state <= S_IFG;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_sequencer.sv
// Randomized self-checking bench for eth_tx_frame_sequencer against a frame-level
// reference model (expected byte stream built from payload, pad and bitwise CRC).
module tb_eth_tx_frame_sequencer;
  localparam int PRE  = 7;
  localparam int MINF = 60;
  localparam int IFG  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        underrun;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  eth_tx_frame_sequencer #(.PREAMBLE_LEN(PRE), .MIN_FRAME(MINF), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .underrun(underrun), .frame_count(frame_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fc  = 0;

  logic [7:0] src_data[$];
  bit         src_last[$];
  logic [7:0] cap[$];
  int         cap_edge[$];
  int         rise_edge[$];
  int         ur_edges[$];
  logic [7:0] exp_q[$];
  int         edge_no = 0;
  bit         ov_prev = 1'b0;
  bit         stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;
  int         stall_err = 0;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_crc(input logic [7:0] msg[$]);
    logic [31:0] c;
    bit fb;
    c = 32'hFFFFFFFF;
    foreach (msg[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = msg[i][j] ^ c[0];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic build_expected(input logic [7:0] pl[$]);
    logic [7:0] body[$];
    logic [31:0] crc;
    body = pl;
    while (body.size() < MINF) body.push_back(8'h00);
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    crc = model_crc(body);
    for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
  endtask

  task automatic push_frame(input logic [7:0] pl[$]);
    foreach (pl[i]) begin
      src_data.push_back(pl[i]);
      src_last.push_back(i == pl.size() - 1);
    end
  endtask

  task automatic clear_capture();
    cap.delete(); cap_edge.delete(); rise_edge.delete(); ur_edges.delete();
    stall_err = 0;
  endtask

  task automatic step(input bit rdy);
    bit acc_in, acc_out;
    logic [7:0] d;
    @(negedge clk);
    out_ready = rdy;
    if (src_data.size() > 0) begin
      in_valid = 1'b1; in_data = src_data[0]; in_last = src_last[0];
    end else begin
      in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    end
    #1;
    if (stall_pend && (!out_valid || out_data !== stall_data)) stall_err++;
    if (underrun) ur_edges.push_back(edge_no);
    if (out_valid && !ov_prev) rise_edge.push_back(edge_no);
    ov_prev    = out_valid;
    acc_in     = in_valid && in_ready;
    acc_out    = out_valid && out_ready;
    d          = out_data;
    stall_pend = out_valid && !out_ready;
    stall_data = out_data;
    @(posedge clk);
    edge_no++;
    if (acc_in) begin
      void'(src_data.pop_front());
      void'(src_last.pop_front());
    end
    if (acc_out) begin
      cap.push_back(d);
      cap_edge.push_back(edge_no);
    end
  endtask

  task automatic run_until(input int n, input int budget, input bit rand_rdy);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      step(rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
      k++;
    end
  endtask

  task automatic rand_payload(input int len, output logic [7:0] pl[$]);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1); step(1'b1);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    rst = 1'b0;
    step(1'b1);
  endtask

  task automatic test_crc_string();
    logic [7:0] msg[$];
    logic [31:0] c;
    for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
    c = model_crc(msg);
    n_tests++; if (c !== 32'hCBF43926) begin n_fail++; $display("FAIL crc_123456789: got %h want cbf43926", c); end
  endtask

  task automatic test_one_byte();
    logic [7:0] pl[$];
    int errs, first;
    clear_capture();
    pl.push_back(8'hAB);
    build_expected(pl);
    push_frame(pl);
    run_until(exp_q.size(), 400, 1'b0);
    errs = 0; first = -1;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) begin errs++; if (first < 0) first = i; end
    n_tests++;
    if (cap.size() != exp_q.size() || errs != 0) begin
      n_fail++; $display("FAIL one_byte_seq: %0d bytes, %0d wrong (first %0d), want %0d bytes", cap.size(), errs, first, exp_q.size());
    end
    n_tests++;
    if (cap.size() != 72 || cap_edge[cap.size()-1] - cap_edge[0] != 71) begin
      n_fail++; $display("FAIL one_byte_contiguous: %0d bytes, want 72 on consecutive edges", cap.size());
    end
    exp_fc++;
    repeat (20) step(1'b1);
    #1;
    n_tests++; if (cap.size() != 72) begin n_fail++; $display("FAIL one_byte_tail: got %0d bytes want 72", cap.size()); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL one_byte_idle: busy %b want 0", busy); end
    n_tests++; if (frame_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL one_byte_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_64_bytes();
    logic [7:0] pl[$];
    int errs, first;
    clear_capture();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    build_expected(pl);
    push_frame(pl);
    run_until(exp_q.size(), 400, 1'b0);
    errs = 0; first = -1;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) begin errs++; if (first < 0) first = i; end
    n_tests++;
    if (cap.size() != 76 || errs != 0) begin
      n_fail++; $display("FAIL frame64_seq: %0d bytes, %0d wrong (first %0d), want 76 bytes", cap.size(), errs, first);
    end
    exp_fc++;
    repeat (20) step(1'b1);
    #1;
    n_tests++; if (frame_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL frame64_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_stall();
    logic [7:0] pl[$];
    int errs, first;
    clear_capture();
    rand_payload(100, pl);
    build_expected(pl);
    push_frame(pl);
    run_until(exp_q.size(), 3000, 1'b1);
    errs = 0; first = -1;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) begin errs++; if (first < 0) first = i; end
    n_tests++;
    if (cap.size() != exp_q.size() || errs != 0) begin
      n_fail++; $display("FAIL stall_seq: %0d bytes, %0d wrong (first %0d), want %0d bytes", cap.size(), errs, first, exp_q.size());
    end
    n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold: %0d cycles changed while stalled, want 0", stall_err); end
    exp_fc++;
    repeat (20) step(1'b1);
    #1;
    n_tests++; if (frame_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_underrun();
    logic [7:0] full[$];
    logic [7:0] pl[$];
    int errs, first, k;
    clear_capture();
    rand_payload(30, full);
    build_expected(full);
    for (int i = 0; i < 10; i++) begin src_data.push_back(full[i]); src_last.push_back(1'b0); end
    k = 0;
    while (src_data.size() > 0 && k < 200) begin step(1'b1); k++; end
    repeat (5) step(1'b1);
    #1;
    n_tests++; if (ur_edges.size() != 1) begin n_fail++; $display("FAIL underrun_pulse: high for %0d cycles want 1", ur_edges.size()); end
    n_tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL underrun_drain_state: busy %b out_valid %b want 1/0", busy, out_valid); end
    errs = 0; first = -1;
    for (int i = 0; i < cap.size() && i < 18; i++)
      if (cap[i] !== exp_q[i]) begin errs++; if (first < 0) first = i; end
    n_tests++;
    if (cap.size() != 18 || errs != 0) begin
      n_fail++; $display("FAIL underrun_prefix: %0d bytes, %0d wrong (first %0d), want 18 bytes", cap.size(), errs, first);
    end
    for (int i = 10; i < 30; i++) begin src_data.push_back(full[i]); src_last.push_back(i == 29); end
    k = 0;
    while (src_data.size() > 0 && k < 200) begin step(1'b1); k++; end
    n_tests++; if (src_data.size() != 0) begin n_fail++; $display("FAIL underrun_drain: %0d bytes left want 0", src_data.size()); end
    repeat (20) step(1'b1);
    #1;
    n_tests++; if (cap.size() != 18) begin n_fail++; $display("FAIL underrun_no_fcs: got %0d bytes want 18", cap.size()); end
    n_tests++; if (frame_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL underrun_count: got %0d want %0d", frame_count, exp_fc); end
    clear_capture();
    rand_payload(5, pl);
    build_expected(pl);
    push_frame(pl);
    run_until(exp_q.size(), 400, 1'b0);
    errs = 0; first = -1;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) begin errs++; if (first < 0) first = i; end
    n_tests++;
    if (cap.size() != exp_q.size() || errs != 0) begin
      n_fail++; $display("FAIL underrun_next_frame: %0d bytes, %0d wrong (first %0d), want %0d", cap.size(), errs, first, exp_q.size());
    end
    exp_fc++;
    repeat (20) step(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    logic [7:0] e_all[$];
    int n1, errs, first, gap;
    clear_capture();
    rand_payload($urandom_range(1, 70), p1);
    rand_payload($urandom_range(1, 70), p2);
    build_expected(p1);
    e_all = exp_q;
    n1 = exp_q.size();
    build_expected(p2);
    foreach (exp_q[i]) e_all.push_back(exp_q[i]);
    push_frame(p1);
    push_frame(p2);
    run_until(e_all.size(), 800, 1'b0);
    errs = 0; first = -1;
    for (int i = 0; i < cap.size() && i < e_all.size(); i++)
      if (cap[i] !== e_all[i]) begin errs++; if (first < 0) first = i; end
    n_tests++;
    if (cap.size() != e_all.size() || errs != 0) begin
      n_fail++; $display("FAIL b2b_seq: %0d bytes, %0d wrong (first %0d), want %0d", cap.size(), errs, first, e_all.size());
    end
    gap = (rise_edge.size() >= 2 && cap_edge.size() >= n1) ? rise_edge[1] - cap_edge[n1-1] : -1;
    n_tests++; if (gap != IFG + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles want %0d", gap, IFG + 1); end
    exp_fc += 2;
    repeat (20) step(1'b1);
    #1;
    n_tests++; if (frame_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_rst_pad();
    logic [7:0] pl[$];
    int errs, first;
    clear_capture();
    rand_payload(3, pl);
    push_frame(pl);
    run_until(PRE + 1 + 3 + 5, 200, 1'b0);
    #1 rst = 1'b1;
    step(1'b1);
    #1;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_pad_state: out_valid %b busy %b want 0/0", out_valid, busy); end
    n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_pad_count: got %0d want 0", frame_count); end
    rst = 1'b0;
    exp_fc = 0;
    step(1'b1); step(1'b1);
    clear_capture();
    rand_payload(20, pl);
    build_expected(pl);
    push_frame(pl);
    run_until(exp_q.size(), 400, 1'b0);
    errs = 0; first = -1;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) begin errs++; if (first < 0) first = i; end
    n_tests++;
    if (cap.size() != exp_q.size() || errs != 0) begin
      n_fail++; $display("FAIL rst_pad_next_frame: %0d bytes, %0d wrong (first %0d), want %0d", cap.size(), errs, first, exp_q.size());
    end
    exp_fc++;
    repeat (20) step(1'b1);
    #1;
    n_tests++; if (frame_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL rst_pad_final_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  initial begin
    test_reset();
    test_crc_string();
    test_one_byte();
    test_64_bytes();
    test_stall();
    test_underrun();
    test_back_to_back();
    test_rst_pad();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
